// File: rtl/ram_copy_pkg.sv
// ram_copy_pkg: shared widths and state/direction types for the block-copy engine
package ram_copy_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 6;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} copy_state_t;
  typedef enum logic {ASC, DESC} copy_dir_t;
endpackage

// File: rtl/ram_copy_engine.sv
// ram_copy_engine: copies len words from src to dst through a single-port memory, overlap-safe
module ram_copy_engine #(
  parameter int DATA_W = ram_copy_pkg::DATA_W,
  parameter int ADDR_W = ram_copy_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_rdata
);
  import ram_copy_pkg::copy_state_t, ram_copy_pkg::copy_dir_t;
  import ram_copy_pkg::IDLE, ram_copy_pkg::READ, ram_copy_pkg::WRITE, ram_copy_pkg::DONE;
  import ram_copy_pkg::ASC, ram_copy_pkg::DESC;
  copy_state_t state;
  copy_dir_t dir;
  logic [ADDR_W-1:0] src_a, dst_a, back;
  logic [ADDR_W:0] cnt, src_end;
  logic [DATA_W-1:0] data;
  logic overlap;
  // dst inside (src, src+len) means an ascending copy would clobber unread source words
  assign src_end = {1'b0, src} + len;
  assign overlap = ({1'b0, dst} > {1'b0, src}) && ({1'b0, dst} < src_end);
  assign back = ADDR_W'(len - 1'b1);
  assign busy = state == READ || state == WRITE;
  assign done = state == DONE;
  assign mem_load = state == WRITE;
  assign mem_addr = state == WRITE ? dst_a : src_a;
  assign mem_wdata = data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dir <= ASC;
      src_a <= '0;
      dst_a <= '0;
      cnt <= '0;
      data <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dir <= overlap ? DESC : ASC;
          src_a <= overlap ? src + back : src;
          dst_a <= overlap ? dst + back : dst;
          cnt <= len;
          state <= len == '0 ? DONE : READ;
        end
        READ: begin
          data <= mem_rdata;
          state <= WRITE;
        end
        WRITE: begin
          src_a <= dir == DESC ? src_a - 1'b1 : src_a + 1'b1;
          dst_a <= dir == DESC ? dst_a - 1'b1 : dst_a + 1'b1;
          cnt <= cnt - 1'b1;
          state <= cnt == (ADDR_W+1)'(1) ? DONE : READ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_copy_engine.sv
// tb_ram_copy_engine: scoreboarded directed tests of the block-copy engine against a word memory
module tb_ram_copy_engine;
  import ram_copy_pkg::*;
  typedef struct packed {logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;} wr_t;
  logic clk = 1'b0;
  logic rst_n, start, busy, done, mem_load;
  logic [ADDR_W-1:0] src, dst, mem_addr;
  logic [ADDR_W:0] len;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [DATA_W-1:0] mem [64];
  logic [DATA_W-1:0] model [64];
  wr_t exp_q[$];
  int tests = 0, fails = 0, done_seen = 0;
  int cyc, bn, ld, d0;

  always #5 clk = ~clk;

  ram_copy_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_load(mem_load), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_load) mem[mem_addr] <= mem_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // every write the DUT commits must be the next one the model predicted
  always @(negedge clk) begin : monitor
    wr_t e;
    if (done) done_seen++;
    if (rst_n && mem_load) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data %0h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e.a));
        check("wr_data", mem_wdata, e.d);
      end
    end
  end

  task automatic fill();
    for (int i = 0; i < 64; i++) begin
      mem[i] = 64'(i);
      model[i] = 64'(i);
    end
  endtask

  task automatic expect_copy(input int s, input int d, input int l, input int k);
    wr_t w;
    bit desc;
    int sa, da;
    desc = (d > s) && (d < s + l);
    sa = desc ? s + l - 1 : s;
    da = desc ? d + l - 1 : d;
    for (int i = 0; i < k; i++) begin
      w.a = 6'(da);
      w.d = model[6'(sa)];
      exp_q.push_back(w);
      model[w.a] = w.d;
      sa += desc ? -1 : 1;
      da += desc ? -1 : 1;
    end
  endtask

  task automatic mem_check(input string name);
    int bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== model[i]) bad++;
    check(name, 64'(bad), 0);
  endtask

  task automatic run_copy(input int s, input int d, input int l, input int poke,
                          output int c, output int b, output int lds);
    @(negedge clk);
    src = 6'(s);
    dst = 6'(d);
    len = 7'(l);
    start = 1'b1;
    c = 0;
    b = 0;
    lds = 0;
    do begin
      @(negedge clk);
      c++;
      b += int'(busy);
      lds += int'(mem_load);
      start = poke != 0 && c == poke;
      if (start) begin
        src = 6'd50;
        dst = 6'd51;
        len = 7'd3;
      end
    end while (!done && c < 300);
    start = 1'b0;
    check("done_pulse", 64'(done), 1);
    check("busy_in_done", 64'(busy), 0);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 0);
    check("queue_drained", 64'(exp_q.size()), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    src = '0;
    dst = '0;
    len = '0;
    fill();
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_load", 64'(mem_load), 0);
    check("rst_addr", 64'(mem_addr), 0);
    check("rst_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    fill();
    expect_copy(0, 32, 8, 8);
    run_copy(0, 32, 8, 0, cyc, bn, ld);
    check("t1_done_cycle", 64'(cyc), 17);
    check("t1_busy_cycles", 64'(bn), 16);
    mem_check("t1_mem");
    check("t1_w32", mem[32], 0);
    check("t1_w39", mem[39], 7);
    check("t1_w40", mem[40], 40);
    check("t1_w31", mem[31], 31);

    fill();
    expect_copy(10, 12, 5, 5);
    run_copy(10, 12, 5, 0, cyc, bn, ld);
    mem_check("t2_mem");
    check("t2_w12", mem[12], 10);
    check("t2_w16", mem[16], 14);
    check("t2_w10", mem[10], 10);
    check("t2_w11", mem[11], 11);

    fill();
    expect_copy(12, 10, 5, 5);
    run_copy(12, 10, 5, 0, cyc, bn, ld);
    mem_check("t3_mem");
    check("t3_w10", mem[10], 12);
    check("t3_w14", mem[14], 16);
    check("t3_w15", mem[15], 15);

    // ascending wrap: source words 2,3 are overwritten before being read, so words 8,9 get 60,61
    fill();
    expect_copy(60, 2, 8, 8);
    run_copy(60, 2, 8, 0, cyc, bn, ld);
    mem_check("t4_mem");
    check("t4_w2", mem[2], 60);
    check("t4_w5", mem[5], 63);
    check("t4_w6", mem[6], 0);
    check("t4_w7", mem[7], 1);
    check("t4_w8", mem[8], 60);
    check("t4_w10", mem[10], 10);

    run_copy(5, 9, 0, 0, cyc, bn, ld);
    check("t5_done_cycle", 64'(cyc), 1);
    check("t5_busy_cycles", 64'(bn), 0);
    check("t5_loads", 64'(ld), 0);
    mem_check("t5_mem");

    fill();
    d0 = done_seen;
    expect_copy(20, 40, 4, 4);
    run_copy(20, 40, 4, 3, cyc, bn, ld);
    check("t6_done_cycle", 64'(cyc), 9);
    check("t6_busy_cycles", 64'(bn), 8);
    repeat (6) @(negedge clk);
    check("t6_one_done", 64'(done_seen - d0), 1);
    check("t6_busy_idle", 64'(busy), 0);
    mem_check("t6_mem");

    fill();
    expect_copy(20, 44, 8, 2);
    d0 = done_seen;
    @(negedge clk);
    src = 6'd20;
    dst = 6'd44;
    len = 7'd8;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    check("t7_busy_before", 64'(busy), 1);
    check("t7_addr_before", 64'(mem_addr), 22);
    #2 rst_n = 1'b0;
    #1;
    check("t7_async_busy", 64'(busy), 0);
    check("t7_async_load", 64'(mem_load), 0);
    check("t7_async_addr", 64'(mem_addr), 0);
    check("t7_async_done", 64'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t7_no_done", 64'(done_seen - d0), 0);
    check("t7_queue", 64'(exp_q.size()), 0);
    mem_check("t7_mem_partial");
    check("t7_w44", mem[44], 20);
    check("t7_w45", mem[45], 21);
    check("t7_w46", mem[46], 46);
    expect_copy(20, 44, 8, 8);
    run_copy(20, 44, 8, 0, cyc, bn, ld);
    check("t7_done_cycle", 64'(cyc), 17);
    mem_check("t7_mem_full");
    check("t7_w51", mem[51], 27);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
